// File: rtl/snoop_fifo_wr_sched_if.sv
// Requester-side and FIFO-side bus of the snoopable FIFO write scheduler.
interface snoop_fifo_wr_sched_if #(
    parameter int unsigned DW   = 64,
    parameter int unsigned NREQ = 3
);
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ack;
    logic [NREQ-1:0]    req_dup;
    logic               dedup_en;
    logic [DW-1:0]      f_wdata;
    logic               f_wvalid;
    logic               f_wready;
    logic [DW-1:0]      f_sdata;
    logic               f_svalid;
    logic               f_smatch;

    // Scheduler side
    modport master (
        input  req_data, req_valid, dedup_en, f_wready, f_smatch,
        output req_ack, req_dup, f_wdata, f_wvalid, f_sdata, f_svalid
    );

    // Requesters plus FIFO side
    modport slave (
        output req_data, req_valid, dedup_en, f_wready, f_smatch,
        input  req_ack, req_dup, f_wdata, f_wvalid, f_sdata, f_svalid
    );
endinterface

// File: rtl/snoop_fifo_wr_sched.sv
// Round-robin write scheduler for the snoopable FIFO with optional snoop-and-drop dedup.
module snoop_fifo_wr_sched #(
    parameter int unsigned DW        = 64,
    parameter int unsigned NREQ      = 3,
    parameter int unsigned SNOOP_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    snoop_fifo_wr_sched_if.master bus,
    output logic [15:0]           drop_cnt_o,
    output logic                  busy_o
);
    localparam int unsigned PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned WCW = $clog2(SNOOP_LAT) + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SNOOP = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DROP  = 3'd4
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   rr_ptr_q;
    logic [PW-1:0]   gnt_q;
    logic [DW-1:0]   hold_data_q;
    logic [WCW-1:0]  wait_cnt_q;
    logic [15:0]     drop_cnt_q;

    logic            any_valid_c;
    logic [PW-1:0]   pick_c;
    logic [DW-1:0]   pick_data_c;
    logic [PW-1:0]   rr_ptr_d;
    logic            done_c;
    logic [NREQ-1:0] gnt_onehot_c;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ
    always_comb begin
        int unsigned idx;
        int unsigned base;
        any_valid_c = 1'b0;
        pick_c      = rr_ptr_q;
        idx         = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(rr_ptr_q) + k) % NREQ;
            if (!any_valid_c && bus.req_valid[idx]) begin
                any_valid_c = 1'b1;
                pick_c      = PW'(idx);
            end
        end
        base        = 32'(pick_c) * DW;
        pick_data_c = bus.req_data[base +: DW];
    end

    // Pointer moves just past the requester that completed
    assign rr_ptr_d     = (gnt_q == PW'(NREQ - 1)) ? '0 : gnt_q + PW'(1);
    assign done_c       = ((state_q == WRITE) && bus.f_wready) || (state_q == DROP);
    assign gnt_onehot_c = NREQ'(1) << gnt_q;

    // Handshake strobes decoded from the state register
    assign bus.req_ack  = done_c ? gnt_onehot_c : '0;
    assign bus.req_dup  = (state_q == DROP) ? gnt_onehot_c : '0;
    assign bus.f_wvalid = (state_q == WRITE);
    assign bus.f_svalid = (state_q == SNOOP);
    assign bus.f_wdata  = hold_data_q;
    assign bus.f_sdata  = hold_data_q;
    assign drop_cnt_o   = drop_cnt_q;
    assign busy_o       = (state_q != IDLE);

    // Transaction FSM: grant, optional snoop/wait, then write or drop
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            hold_data_q <= '0;
            wait_cnt_q  <= '0;
            drop_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_valid_c) begin
                        gnt_q       <= pick_c;
                        hold_data_q <= pick_data_c;
                        state_q     <= bus.dedup_en ? SNOOP : WRITE;
                    end
                end
                SNOOP: begin
                    wait_cnt_q <= '0;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt_q == WCW'(SNOOP_LAT - 1)) begin
                        wait_cnt_q <= '0;
                        state_q    <= bus.f_smatch ? DROP : WRITE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WCW'(1);
                    end
                end
                WRITE: begin
                    if (bus.f_wready) begin
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= IDLE;
                    end
                end
                DROP: begin
                    rr_ptr_q <= rr_ptr_d;
                    if (drop_cnt_q != 16'hFFFF) begin
                        drop_cnt_q <= drop_cnt_q + 16'd1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snoop_fifo_wr_sched.sv
// Bench for snoop_fifo_wr_sched: directed scenarios plus randomized batches against a transaction-level model.
module tb_snoop_fifo_wr_sched;
    localparam int unsigned DW        = 64;
    localparam int unsigned NREQ      = 3;
    localparam int unsigned SNOOP_LAT = 2;
    localparam int          MAXC      = 300;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] drop_cnt;
    logic        busy;

    always #5 clk = ~clk;

    snoop_fifo_wr_sched_if #(.DW(DW), .NREQ(NREQ)) bus ();

    snoop_fifo_wr_sched #(.DW(DW), .NREQ(NREQ), .SNOOP_LAT(SNOOP_LAT)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .drop_cnt_o (drop_cnt),
        .busy_o     (busy)
    );

    int total = 0;
    int bad   = 0;
    int wr_mode;     // 0 random ready, 1 always ready, 2 never ready
    bit auto_drop;   // requester drops req_valid on its ack
    int snp_timer;
    logic snp_res;
    int proto_err;

    logic [DW-1:0] env_fifo [$];
    logic [DW-1:0] mdl_fifo [$];
    logic [DW-1:0] wr_log   [$];
    int            ack_log  [$];
    logic          dup_log  [$];

    logic [NREQ-1:0] o_ack, o_dup;
    logic            o_wv, o_sv, o_busy;
    logic [DW-1:0]   o_wd, o_sd;

    function automatic bit in_q(input logic [DW-1:0] q[$], input logic [DW-1:0] d);
        foreach (q[i]) if (q[i] === d) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive FIFO inputs at negedge, then sample outputs and play FIFO/requesters
    task automatic step();
        @(negedge clk);
        case (wr_mode)
            1:       bus.f_wready = 1'b1;
            2:       bus.f_wready = 1'b0;
            default: bus.f_wready = ($urandom_range(0, 3) != 0);
        endcase
        if (snp_timer > 0) begin
            snp_timer--;
            bus.f_smatch = (snp_timer == 0) ? snp_res : ~snp_res;
        end else begin
            bus.f_smatch = 1'b0;
        end
        #1;
        o_ack  = bus.req_ack;
        o_dup  = bus.req_dup;
        o_wv   = bus.f_wvalid;
        o_wd   = bus.f_wdata;
        o_sv   = bus.f_svalid;
        o_sd   = bus.f_sdata;
        o_busy = busy;
        if (o_sv) begin
            snp_res   = in_q(env_fifo, o_sd);
            snp_timer = SNOOP_LAT;
        end
        if (o_wv && bus.f_wready) begin
            env_fifo.push_back(o_wd);
            wr_log.push_back(o_wd);
        end
        if (((o_dup & ~o_ack) != '0) || ($countones(o_ack) > 1)) proto_err++;
        for (int i = 0; i < NREQ; i++) begin
            if (o_ack[i]) begin
                ack_log.push_back(i);
                dup_log.push_back(o_dup[i]);
                if (auto_drop) bus.req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ack"},    64'(bus.req_ack), 64'd0);
        check({tag, "_dup"},    64'(bus.req_dup), 64'd0);
        check({tag, "_wvalid"}, 64'(bus.f_wvalid), 64'd0);
        check({tag, "_svalid"}, 64'(bus.f_svalid), 64'd0);
        check({tag, "_wdata"},  bus.f_wdata, 64'd0);
        check({tag, "_sdata"},  bus.f_sdata, 64'd0);
        check({tag, "_dropcnt"}, 64'(drop_cnt), 64'd0);
        check({tag, "_busy"},   64'(busy), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_zero_outputs("rst");
        snp_timer    = 0;
        bus.f_smatch = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic clear_logs();
        wr_log.delete();
        ack_log.delete();
        dup_log.delete();
    endtask

    initial begin
        logic [DW-1:0] pool [8];
        logic [DW-1:0] bdata [NREQ];
        int            exp_ack [$];
        logic          exp_dup [$];
        logic [DW-1:0] exp_wr  [$];
        logic [NREQ-1:0] set;
        logic [NREQ-1:0] exp_pat;
        bit   dd, any_dup, dup;
        int   m_ptr, m_drops, last, n, npop, idx;

        rstn          = 1'b0;
        bus.req_data  = '0;
        bus.req_valid = '0;
        bus.dedup_en  = 1'b0;
        bus.f_wready  = 1'b0;
        bus.f_smatch  = 1'b0;
        wr_mode = 1; auto_drop = 1'b1; snp_timer = 0; snp_res = 1'b0; proto_err = 0;

        do_reset();

        // Single requester, dedup off
        step();
        clear_logs();
        bus.req_data[0 +: DW] = 64'hA5A5;
        bus.req_valid = 3'b001;
        step();
        check("t1_wvalid", 64'(o_wv), 64'd1);
        check("t1_wdata",  o_wd, 64'hA5A5);
        check("t1_ack",    64'(o_ack), 64'b001);
        step();
        check("t1_idle_ack", 64'(o_ack), 64'd0);
        check("t1_busy",     64'(o_busy), 64'd0);
        check("t1_dropcnt",  64'(drop_cnt), 64'd0);
        check("t1_nwrites",  64'(wr_log.size()), 64'd1);

        // All requesters valid continuously: strict rotation, one-cycle acks
        do_reset();
        step();
        clear_logs();
        auto_drop = 1'b0;
        for (int i = 0; i < NREQ; i++) bus.req_data[i*DW +: DW] = 64'h100 * (i + 1);
        bus.req_valid = 3'b111;
        for (int j = 1; j <= 12; j++) begin
            step();
            exp_pat = (j % 2 == 1) ? (NREQ'(1) << (((j - 1) / 2) % NREQ)) : '0;
            check($sformatf("t2_ack_c%0d", j), 64'(o_ack), 64'(exp_pat));
        end
        bus.req_valid = '0;
        auto_drop = 1'b1;
        check("t2_nwrites", 64'(wr_log.size()), 64'd6);
        for (int k = 0; k < 6 && k < wr_log.size(); k++)
            check($sformatf("t2_wdata%0d", k), wr_log[k], 64'h100 * ((k % NREQ) + 1));

        // Dedup on, snoop hits: drop after SNOOP_LAT wait; dedup_en toggled mid-flight
        step();
        clear_logs();
        env_fifo.push_back(64'h1234);
        bus.dedup_en = 1'b1;
        bus.req_data[1*DW +: DW] = 64'h1234;
        bus.req_valid = 3'b010;
        any_dup = 1'b0;
        step();
        check("t3_svalid_c1", 64'(o_sv), 64'd1);
        check("t3_sdata_c1",  o_sd, 64'h1234);
        bus.dedup_en = 1'b0;
        for (int j = 2; j <= 1 + SNOOP_LAT; j++) begin
            step();
            check($sformatf("t3_ack_c%0d", j), 64'(o_ack), 64'd0);
            check($sformatf("t3_busy_c%0d", j), 64'(o_busy), 64'd1);
        end
        step();
        check("t3_ack",    64'(o_ack), 64'b010);
        check("t3_dup",    64'(o_dup), 64'b010);
        check("t3_wvalid", 64'(o_wv), 64'd0);
        step();
        check("t3_dropcnt", 64'(drop_cnt), 64'd1);
        check("t3_nwrites", 64'(wr_log.size()), 64'd0);

        // Dedup on, snoop misses: written at 2+SNOOP_LAT
        clear_logs();
        bus.dedup_en = 1'b1;
        bus.req_data[0 +: DW] = 64'h5678;
        bus.req_valid = 3'b001;
        for (int j = 1; j <= 1 + SNOOP_LAT; j++) begin
            step();
            check($sformatf("t4_wvalid_c%0d", j), 64'(o_wv), 64'd0);
            any_dup |= (o_dup != '0);
        end
        step();
        any_dup |= (o_dup != '0);
        check("t4_wvalid", 64'(o_wv), 64'd1);
        check("t4_wdata",  o_wd, 64'h5678);
        check("t4_ack",    64'(o_ack), 64'b001);
        step();
        any_dup |= (o_dup != '0);
        check("t4_nodup",   64'(any_dup), 64'd0);
        check("t4_dropcnt", 64'(drop_cnt), 64'd1);

        // FIFO full for 5 cycles: write held stable, no other grant
        clear_logs();
        bus.dedup_en = 1'b0;
        bus.req_data[0 +: DW]  = 64'hAAA0;
        bus.req_data[2*DW +: DW] = 64'hCCC0;
        bus.req_valid = 3'b101;
        wr_mode = 2;
        for (int j = 1; j <= 5; j++) begin
            step();
            check($sformatf("t5_wvalid_c%0d", j), 64'(o_wv), 64'd1);
            check($sformatf("t5_wdata_c%0d", j),  o_wd, 64'hCCC0);
            check($sformatf("t5_ack_c%0d", j),    64'(o_ack), 64'd0);
        end
        wr_mode = 1;
        step();
        check("t5_ack_rel", 64'(o_ack), 64'b100);
        step();
        check("t5_gap_wvalid", 64'(o_wv), 64'd0);
        step();
        check("t5_next_wdata", o_wd, 64'hAAA0);
        check("t5_next_ack",   64'(o_ack), 64'b001);
        step();

        // Reset during WAIT aborts; requester regranted and written once
        clear_logs();
        bus.dedup_en = 1'b1;
        bus.req_data[2*DW +: DW] = 64'hBEEF;
        bus.req_valid = 3'b100;
        step();
        step();
        check("t6_busy_wait", 64'(o_busy), 64'd1);
        do_reset();
        for (int j = 0; j < 10; j++) step();
        check("t6_nwrites", 64'(wr_log.size()), 64'd1);
        if (wr_log.size() > 0) check("t6_wdata", wr_log[0], 64'hBEEF);
        check("t6_nacks", 64'(ack_log.size()), 64'd1);
        if (ack_log.size() > 0) check("t6_ackidx", 64'(ack_log[0]), 64'd2);
        check("t6_dropcnt", 64'(drop_cnt), 64'd0);

        // Randomized batches against a transaction-level model
        do_reset();
        env_fifo.delete();
        mdl_fifo.delete();
        m_ptr = 0; m_drops = 0;
        wr_mode = 0;
        for (int i = 0; i < 8; i++) pool[i] = {$urandom, $urandom};
        for (int b = 0; b < 40; b++) begin
            npop = $urandom_range(0, mdl_fifo.size());
            for (int p = 0; p < npop; p++) begin
                void'(mdl_fifo.pop_front());
                if (env_fifo.size() > 0) void'(env_fifo.pop_front());
            end
            dd  = 1'($urandom_range(0, 1));
            set = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                bdata[i] = pool[$urandom_range(0, 7)];
                bus.req_data[i*DW +: DW] = bdata[i];
            end
            exp_ack.delete(); exp_dup.delete(); exp_wr.delete();
            last = m_ptr;
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (set[idx]) begin
                    dup = dd && in_q(mdl_fifo, bdata[idx]);
                    exp_ack.push_back(idx);
                    exp_dup.push_back(dup);
                    if (dup) begin
                        if (m_drops < 16'hFFFF) m_drops++;
                    end else begin
                        mdl_fifo.push_back(bdata[idx]);
                        exp_wr.push_back(bdata[idx]);
                    end
                    last = idx;
                end
            end
            m_ptr = (last + 1) % NREQ;
            clear_logs();
            bus.dedup_en  = dd;
            bus.req_valid = set;
            n = 0;
            do begin
                step();
                n++;
            end while ((bus.req_valid != '0 || o_busy) && n < MAXC);
            check($sformatf("rb%0d_done", b), 64'(n < MAXC), 64'd1);
            check($sformatf("rb%0d_nacks", b), 64'(ack_log.size()), 64'(exp_ack.size()));
            for (int k = 0; k < exp_ack.size(); k++) begin
                check($sformatf("rb%0d_ack%0d", b, k),
                      (k < ack_log.size()) ? 64'(ack_log[k]) : 64'hFFFF, 64'(exp_ack[k]));
                check($sformatf("rb%0d_dup%0d", b, k),
                      (k < dup_log.size()) ? 64'(dup_log[k]) : 64'hFFFF, 64'(exp_dup[k]));
            end
            check($sformatf("rb%0d_nwr", b), 64'(wr_log.size()), 64'(exp_wr.size()));
            for (int k = 0; k < exp_wr.size() && k < wr_log.size(); k++)
                check($sformatf("rb%0d_wr%0d", b, k), wr_log[k], exp_wr[k]);
            check($sformatf("rb%0d_dropcnt", b), 64'(drop_cnt), 64'(m_drops));
        end

        check("protocol", 64'(proto_err), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/snoop_fifo_wr_sched.md
# snoop_fifo_wr_sched

Write-side scheduler for the team's snoopable FIFO. It shares the FIFO's single write port among NREQ requesters using round-robin arbitration. When deduplication is enabled, it first snoops each granted word against the FIFO contents and drops the word if a matching entry is already queued. It sits between the producer agents and the FIFO's wdata/wvalid/wready and sdata/svalid/smatch ports.

## Interface
- DW, 64: data width; must equal the FIFO data width.
- NREQ, 3: number of requesters, 2..8.
- SNOOP_LAT, 1: cycles from FIFO svalid to a valid smatch, 1..4.
- clk  in  1  clock.
- rstn  in  1  reset; asynchronous, active-low.
- req_data  in  NREQ*DW  requester i data in bits [i*DW +: DW].
- req_valid  in  NREQ  requester i has a word pending; held until its req_ack.
- req_ack  out  NREQ  one-cycle completion pulse to the granted requester (written or dropped).
- req_dup  out  NREQ  one-cycle pulse, coincident with req_ack, when the word was dropped as a duplicate.
- dedup_en  in  1  enable snoop/drop; sampled only in IDLE.
- f_wdata  out  DW  FIFO write data.
- f_wvalid  out  1  FIFO write valid.
- f_wready  in  1  FIFO not full.
- f_sdata  out  DW  FIFO snoop data.
- f_svalid  out  1  FIFO snoop strobe.
- f_smatch  in  1  FIFO snoop result, valid SNOOP_LAT cycles after f_svalid.
- drop_cnt  out  16  saturating count of dropped duplicates.
- busy  out  1  state != IDLE.

## Operation
- FSM states and transitions:
  - IDLE: if any req_valid, grant the first valid requester at or after rr_ptr (wrapping modulo NREQ). Latch gnt index and req_data into hold_data. Go to SNOOP if dedup_en=1, otherwise go to WRITE.
  - SNOOP: f_svalid=1 and f_sdata=hold_data for exactly 1 cycle; go to WAIT.
  - WAIT: stay SNOOP_LAT cycles, counting with wait_cnt. Sample f_smatch in the last WAIT cycle: 1 goes to DROP, 0 goes to WRITE.
  - WRITE: f_wvalid=1 and f_wdata=hold_data until f_wready=1. In the handshake cycle, req_ack[gnt]=1; go to IDLE.
  - DROP: 1 cycle. req_ack[gnt]=1, req_dup[gnt]=1, drop_cnt increments (holds at 16'hFFFF); go to IDLE.
- rr_ptr becomes (gnt+1) mod NREQ on every completion (WRITE handshake or DROP). rr_ptr does not change otherwise.
- Data and grant are latched at grant. Later changes to req_data or deassertion of req_valid by the granted requester do not affect the transaction; such a change is a protocol violation.
- Only one transaction is in flight at a time. The FIFO contents snooped therefore always include every previously accepted word that has not yet been read out.
- req_ack, req_dup, f_wvalid and f_svalid are decoded combinationally from the state register plus f_wready. No other outputs depend combinationally on inputs.
- f_wdata and f_sdata always drive hold_data.
- Reset values: state IDLE, rr_ptr 0, hold_data 0, wait_cnt 0, drop_cnt 0. All outputs are 0 during reset.
- Reset asserted mid-transaction aborts the transaction: no req_ack, no FIFO write. The requester still holds req_valid and is regranted after reset.

## Timing
- Dedup off, f_wready=1: req_valid seen in IDLE at cycle 0; f_wvalid and req_ack at cycle 1; IDLE at cycle 2. Peak throughput is 1 word per 2 cycles.
- Dedup on: SNOOP at cycle 1, WAIT at cycles 2..1+SNOOP_LAT, then WRITE or DROP at cycle 2+SNOOP_LAT. Minimum completion latency is 2+SNOOP_LAT cycles after grant.
- FIFO full: WRITE holds with f_wvalid=1 and stable f_wdata indefinitely. No other requester is granted meanwhile.
- Simultaneous requests: exactly one grant per IDLE visit. Round-robin order guarantees every valid requester is served within NREQ transactions.
- dedup_en changing during a transaction has no effect until the next IDLE.

## Test plan
- Single requester 0, dedup off, f_wready=1, data 64'hA5A5: f_wvalid with f_wdata=64'hA5A5 one cycle after req_valid; req_ack[0] pulses once; drop_cnt stays 0.
- All 3 requesters valid continuously, dedup off: grant order 0,1,2,0,1,2; FIFO receives the words in that order; each req_ack is exactly one cycle wide.
- Dedup on, SNOOP_LAT=2, f_smatch=1 for data 64'h1234: f_svalid at cycle 1, smatch sampled at cycle 3; req_ack and req_dup pulse at cycle 4; no f_wvalid; drop_cnt=1.
- Dedup on, f_smatch=0: f_wvalid at cycle 2+SNOOP_LAT; req_dup never asserted.
- f_wready=0 for 5 cycles in WRITE: f_wvalid stays high with f_wdata stable. On f_wready=1, req_ack pulses in the same cycle. A second requester is not granted until after that.
- Assert rstn=0 during WAIT: all outputs go to 0 immediately and drop_cnt=0. After release, the same requester is regranted and its word is written exactly once.
